// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 3-digit common-anode seven-segment scanner with per-frame BCD snapshot.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros in the y2/y1 positions.
module bcd_display_scanner #(
    parameter int REFRESH_DIV  = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] y2,
    input  logic [3:0] y1,
    input  logic [3:0] y0,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int              CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [1:0]      IDX_LAST   = 2'd2;
    localparam logic [1:0]      IDX_BAD    = 2'd3;
    localparam logic [6:0]      SEG_BLANK  = 7'h7F;
    localparam logic [2:0]      AN_OFF     = 3'b111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [11:0]      r_snap;
    logic [2:0]       r_an_p1;
    logic [6:0]       r_seg_p1;
    logic             r_tick_p1;

    logic             w_cnt_wrap;
    logic             w_frame_end;
    logic             w_blank;
    logic             w_lz;
    logic [3:0]       w_digit;
    logic [2:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;

    assign w_cnt_wrap  = (r_cnt >= CNT_LAST);
    assign w_frame_end = w_cnt_wrap && (r_idx == IDX_LAST);

    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            assign w_blank = (r_cnt < CNT_W'(BLANK_CYCLES));
        end else begin : g_noblank
            assign w_blank = 1'b0;
        end
    endgenerate

    // Slot/digit sequencing and end-of-frame snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_snap <= '0;
        end else begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
            if (r_idx == IDX_BAD) begin
                r_idx <= '0;
            end else if (w_cnt_wrap) begin
                r_idx <= (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
            end
            if (w_frame_end) begin
                r_snap <= {y2, y1, y0};
            end
        end
    end

    always_comb begin
        w_digit = r_snap[3:0];
        case (r_idx)
            2'd1:    w_digit = r_snap[7:4];
            2'd2:    w_digit = r_snap[11:8];
            default: w_digit = r_snap[3:0];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign w_lz = ((r_idx == 2'd2) && (r_snap[11:8] == 4'd0)) ||
                  ((r_idx == 2'd1) && (r_snap[11:8] == 4'd0) && (r_snap[7:4] == 4'd0));
`else
    assign w_lz = 1'b0;
`endif

    // An unreachable idx value is shown as blank so at most one anode is ever active
    always_comb begin
        w_an_nxt  = AN_OFF;
        w_seg_nxt = SEG_BLANK;
        if (!w_blank && (r_idx != IDX_BAD)) begin
            w_an_nxt  = ~(3'b001 << r_idx);
            w_seg_nxt = w_lz ? SEG_BLANK : bcd_to_seg(w_digit);
        end
    end

    // Output register stage: one cycle behind (idx, cnt)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an_p1   <= AN_OFF;
            r_seg_p1  <= SEG_BLANK;
            r_tick_p1 <= 1'b0;
        end else begin
            r_an_p1   <= w_an_nxt;
            r_seg_p1  <= w_seg_nxt;
            r_tick_p1 <= w_frame_end;
        end
    end

    assign an         = r_an_p1;
    assign seg        = r_seg_p1;
    assign frame_tick = r_tick_p1;

endmodule
